// File: rtl/test_harness_ctrl_pkg.sv
// Shared types and defaults for the CPU test harness controller.
// Holds the FSM state encoding and default sizing constants.
package test_harness_ctrl_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_NCHK     = 4;
  localparam int DEF_HOLD_CYC = 10;
  localparam int DEF_RUN_CYC  = 100;

  localparam int REG_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/harness_chk_table.sv
// Register-check table: NCHK entries of {enable, register, value}.
// One write port; one combinational indexed read port.
module harness_chk_table
  import test_harness_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NCHK   = DEF_NCHK,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic              i_wen,
  input  logic [REG_W-1:0]  i_wreg,
  input  logic [DATA_W-1:0] i_wval,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic              o_ren,
  output logic [REG_W-1:0]  o_rreg,
  output logic [DATA_W-1:0] o_rval
);

  logic [NCHK-1:0]   r_en;
  logic [REG_W-1:0]  r_reg [NCHK];
  logic [DATA_W-1:0] r_val [NCHK];

  logic w_wr_ok;
  assign w_wr_ok = i_we && (int'(i_widx) < NCHK);

  // Enable bits are cleared by reset so a fresh run checks nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en <= '0;
    end else if (w_wr_ok) begin
      r_en[i_widx] <= i_wen;
    end
  end

  // Payload storage needs no reset; it is qualified by the enable bit.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_reg[i_widx] <= i_wreg;
      r_val[i_widx] <= i_wval;
    end
  end

  assign o_ren  = r_en[i_ridx];
  assign o_rreg = r_reg[i_ridx];
  assign o_rval = r_val[i_ridx];

endmodule

// File: rtl/test_harness_ctrl.sv
// CPU test harness sequencer: load program, hold reset, free-run,
// then compare selected registers against an expectation table.
module test_harness_ctrl
  import test_harness_ctrl_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  ADDR_W   = DEF_ADDR_W,
  parameter int  NCHK     = DEF_NCHK,
  parameter int  HOLD_CYC = DEF_HOLD_CYC,
  parameter int  RUN_CYC  = DEF_RUN_CYC,
  localparam int IDX_W    = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [DATA_W-1:0] rom_wdata,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [REG_W-1:0]  exp_reg,
  input  logic [DATA_W-1:0] exp_val,
  input  logic              exp_en,
  output logic              cpu_rst,
  output logic              cpu_stall,
  output logic [REG_W-1:0]  dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              done,
  output logic              pass,
  output logic              ovf,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_val
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [31:0] RUN_LAST  = 32'(RUN_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHK - 1);

  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [31:0]       r_cnt, w_cnt_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic              r_ph, w_ph_n;
  logic              r_done, w_done_n;
  logic              r_pass, w_pass_n;
  logic              r_ovf, w_ovf_n;
  logic [IDX_W-1:0]  r_fidx, w_fidx_n;
  logic [DATA_W-1:0] r_fval, w_fval_n;
  logic              w_beat;
  logic              w_tbl_we;
  logic              w_ren;
  logic [REG_W-1:0]  w_rreg;
  logic [DATA_W-1:0] w_rval;

  // The table is only writable while no run is in flight.
  assign w_tbl_we = exp_we &&
    ((r_state == S_IDLE) || (r_state == S_DONE));

  harness_chk_table #(
    .DATA_W (DATA_W),
    .NCHK   (NCHK),
    .IDX_W  (IDX_W)
  ) u_tbl (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_tbl_we),
    .i_widx (exp_idx),
    .i_wen  (exp_en),
    .i_wreg (exp_reg),
    .i_wval (exp_val),
    .i_ridx (r_idx),
    .o_ren  (w_ren),
    .o_rreg (w_rreg),
    .o_rval (w_rval)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ph    <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_ovf   <= 1'b0;
      r_fidx  <= '0;
      r_fval  <= '0;
    end else begin
      r_state <= w_nxt;
      r_addr  <= w_addr_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_ph    <= w_ph_n;
      r_done  <= w_done_n;
      r_pass  <= w_pass_n;
      r_ovf   <= w_ovf_n;
      r_fidx  <= w_fidx_n;
      r_fval  <= w_fval_n;
    end
  end

  // Next-state and datapath update; an enabled check entry takes an
  // address cycle (r_ph=0) and a compare cycle (r_ph=1).
  always_comb begin
    w_nxt    = r_state;
    w_addr_n = r_addr;
    w_cnt_n  = r_cnt;
    w_idx_n  = r_idx;
    w_ph_n   = r_ph;
    w_done_n = r_done;
    w_pass_n = r_pass;
    w_ovf_n  = r_ovf;
    w_fidx_n = r_fidx;
    w_fval_n = r_fval;
    w_beat   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nxt    = S_LOAD;
          w_addr_n = '0;
          w_done_n = 1'b0;
          w_pass_n = 1'b0;
          w_ovf_n  = 1'b0;
          w_fidx_n = '0;
          w_fval_n = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          w_beat = 1'b1;
          if (load_last) begin
            w_nxt   = S_HOLD;
            w_cnt_n = '0;
          end else if (r_addr == '1) begin
            w_nxt    = S_DONE;
            w_ovf_n  = 1'b1;
            w_pass_n = 1'b0;
            w_done_n = 1'b1;
          end else begin
            w_addr_n = r_addr + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_nxt   = S_RUN;
          w_cnt_n = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == RUN_LAST) begin
          w_nxt   = S_CHECK;
          w_idx_n = '0;
          w_ph_n  = 1'b0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_CHECK: begin
        if (w_ren && !r_ph) begin
          w_ph_n = 1'b1;
        end else begin
          w_ph_n = 1'b0;
          if (w_ren && (dbg_rdata != w_rval)) begin
            w_nxt    = S_DONE;
            w_fidx_n = r_idx;
            w_fval_n = dbg_rdata;
            w_pass_n = 1'b0;
            w_done_n = 1'b1;
          end else if (r_idx == IDX_LAST) begin
            w_nxt    = S_DONE;
            w_pass_n = 1'b1;
            w_done_n = 1'b1;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_LOAD) || (r_state == S_HOLD) ||
                (r_state == S_RUN)  || (r_state == S_CHECK);
  assign load_ready = (r_state == S_LOAD);
  assign rom_we     = w_beat;
  assign rom_waddr  = r_addr;
  assign rom_wdata  = w_beat ? load_data : '0;
  assign cpu_rst    = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                      (r_state == S_HOLD);
  assign cpu_stall  = (r_state == S_CHECK) || (r_state == S_DONE);
  assign dbg_raddr  = ((r_state == S_CHECK) && w_ren) ? w_rreg : '0;
  assign done       = r_done;
  assign pass       = r_pass;
  assign ovf        = r_ovf;
  assign fail_idx   = r_fidx;
  assign fail_val   = r_fval;

endmodule
